// File: rtl/fc_layer_seq_if.sv
// fc_layer_seq_if -- signal bundle for the fully-connected layer sequencer.
//
// Groups the input stream, frame configuration, weight/bias memory read
// ports, output stream and status flag of fc_layer_seq.
//   slave  : the layer itself (consumes samples, reads memories, emits outputs)
//   master : the environment (sample source, memories, output sink)
//
// Signals:
//   in_valid/in_ready/in_data     input sample stream
//   relu_en, shift                per-frame requant configuration
//   w_addr/w_data                 weight memory, data 1 cycle after address
//   b_addr/b_data                 bias memory, data 1 cycle after address
//   out_valid/out_ready/out_data  requantised neuron output stream
//   out_idx, out_last             neuron index / final-neuron marker
//   busy                          high whenever a frame is being processed
interface fc_layer_seq_if #(
    parameter int IN_SIZE  = 512,
    parameter int OUT_SIZE = 3,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int SHIFT_W  = 5
);
    localparam int W_AW = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1;
    localparam int B_AW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     relu_en;
    logic [SHIFT_W-1:0]       shift;
    logic [W_AW-1:0]          w_addr;
    logic signed [DATA_W-1:0] w_data;
    logic [B_AW-1:0]          b_addr;
    logic signed [ACC_W-1:0]  b_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [B_AW-1:0]          out_idx;
    logic                     out_last;
    logic                     busy;

    modport slave (
        input  in_valid, in_data, relu_en, shift, w_data, b_data, out_ready,
        output in_ready, w_addr, b_addr, out_valid, out_data, out_idx, out_last, busy
    );

    modport master (
        output in_valid, in_data, relu_en, shift, w_data, b_data, out_ready,
        input  in_ready, w_addr, b_addr, out_valid, out_data, out_idx, out_last, busy
    );
endinterface

// File: rtl/fc_layer_seq.sv
// fc_layer_seq -- sequential fully-connected layer.
//
// Buffers one frame of IN_SIZE signed samples, then for each of OUT_SIZE
// neurons computes bias + sum(x[k]*W[n][k]) with a single multiplier,
// requantises (arithmetic shift, optional ReLU, saturation to DATA_W) and
// hands the result out over a valid/ready stream.
//
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   fc_layer_seq_if.slave (streams, memory read ports, config, busy)
//
// State | meaning
// ------+---------------------------------------------------------------
// LOAD  | accept samples into the frame buffer, in_ready=1
// BIAS  | present bias / first weight address for neuron n
// MAC   | one multiply-accumulate per cycle over k=0..IN_SIZE-1
// REQ   | requantise accumulator into the output register
// OUT   | hold output until handshake, then next neuron or back to LOAD
module fc_layer_seq #(
    parameter int IN_SIZE  = 512,
    parameter int OUT_SIZE = 3,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int SHIFT_W  = 5
) (
    input  logic          clk,
    input  logic          rstn,
    fc_layer_seq_if.slave bus
);
    localparam int W_AW = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1;
    localparam int B_AW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int K_W  = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int P_W  = 2 * DATA_W;

    localparam logic [K_W-1:0]  K_LAST = K_W'(IN_SIZE - 1);
    localparam logic [B_AW-1:0] N_LAST = B_AW'(OUT_SIZE - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_BIAS,
        ST_MAC,
        ST_REQ,
        ST_OUT
    } state_t;

    state_t                   state_q, state_d;
    logic [K_W-1:0]           k_q, k_d;
    logic [B_AW-1:0]          n_q, n_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [W_AW-1:0]          w_addr_q, w_addr_d;
    logic [B_AW-1:0]          b_addr_q, b_addr_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic [B_AW-1:0]          out_idx_q, out_idx_d;
    logic                     out_last_q, out_last_d;
    logic                     relu_q, relu_d;
    logic [SHIFT_W-1:0]       shift_q, shift_d;

    logic signed [DATA_W-1:0] buf_q [IN_SIZE];
    logic                     buf_we;

    logic signed [P_W-1:0]    prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  y_sh;
    logic signed [ACC_W-1:0]  y_rl;
    logic signed [ACC_W-1:0]  y_sat;

    // Operands widened first so the product is computed at full precision.
    assign prod     = P_W'(buf_q[k_q]) * P_W'(bus.w_data);
    assign prod_ext = ACC_W'(prod);

    // Requantisation of the finished accumulator.
    always_comb begin
        y_sh  = acc_q >>> shift_q;
        y_rl  = y_sh;
        if (relu_q && y_sh[ACC_W-1]) begin
            y_rl = '0;
        end
        y_sat = y_rl;
        if (y_rl > SAT_MAX) begin
            y_sat = SAT_MAX;
        end else if (y_rl < SAT_MIN) begin
            y_sat = SAT_MIN;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        acc_d       = acc_q;
        w_addr_d    = w_addr_q;
        b_addr_d    = b_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        relu_d      = relu_q;
        shift_d     = shift_q;
        buf_we      = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (bus.in_valid) begin
                    buf_we = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d  = ST_BIAS;
                        k_d      = '0;
                        n_d      = '0;
                        relu_d   = bus.relu_en;
                        shift_d  = bus.shift;
                        w_addr_d = '0;
                        b_addr_d = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end

            ST_BIAS: begin
                state_d = ST_MAC;
                k_d     = '0;
                // Prefetch weight k=1 so it arrives during MAC k=1.
                if (IN_SIZE > 1) begin
                    w_addr_d = w_addr_q + 1'b1;
                end
            end

            ST_MAC: begin
                // Bias seeds the accumulator on the first product; wraps on overflow.
                acc_d = ((k_q == '0) ? bus.b_data : acc_q) + prod_ext;
                if (k_q == K_LAST) begin
                    state_d = ST_REQ;
                end else begin
                    k_d = k_q + 1'b1;
                    if (k_q + 1'b1 != K_LAST) begin
                        w_addr_d = w_addr_q + 1'b1;
                    end
                end
            end

            ST_REQ: begin
                out_data_d  = y_sat[DATA_W-1:0];
                out_idx_d   = n_q;
                out_last_d  = (n_q == N_LAST);
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end

            ST_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (n_q == N_LAST) begin
                        state_d  = ST_LOAD;
                        k_d      = '0;
                        n_d      = '0;
                        w_addr_d = '0;
                        b_addr_d = '0;
                    end else begin
                        state_d  = ST_BIAS;
                        n_d      = n_q + 1'b1;
                        b_addr_d = n_q + 1'b1;
                        // Weight rows are contiguous: next row starts one past
                        // the last address read for this neuron.
                        w_addr_d = w_addr_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_LOAD;
            k_q         <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            w_addr_q    <= '0;
            b_addr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            relu_q      <= 1'b0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            w_addr_q    <= w_addr_d;
            b_addr_q    <= b_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            relu_q      <= relu_d;
            shift_q     <= shift_d;
        end
    end

    // Frame buffer contents are meaningless after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[k_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.busy      = (state_q != ST_LOAD);
    assign bus.w_addr    = w_addr_q;
    assign bus.b_addr    = b_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq -- scoreboard bench for fc_layer_seq (IN_SIZE=4, OUT_SIZE=2).
//
// The stimulus process loads weight/bias memories, streams frames and pushes
// hand-computed expected outputs; a monitor process pops and compares on each
// output handshake and also checks the rise time of every out_valid.
module tb_fc_layer_seq;
    localparam int IN  = 4;
    localparam int OUT = 2;
    localparam int DW  = 8;
    localparam int AW  = 32;
    localparam int SW  = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fc_layer_seq_if #(.IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_W(DW), .ACC_W(AW), .SHIFT_W(SW)) bus ();

    fc_layer_seq #(.IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_W(DW), .ACC_W(AW), .SHIFT_W(SW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        int data;
        int idx;
        int last;
    } exp_t;

    exp_t sbq[$];
    int   tests       = 0;
    int   fails       = 0;
    int   cyc         = 0;
    int   last_accept = -1000;

    logic signed [DW-1:0] wmem [IN*OUT];
    logic signed [AW-1:0] bmem [OUT];
    logic signed [DW-1:0] xv   [IN];

    // cyc is stable between edges: read at a negedge it is the index of the
    // next rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous weight/bias memories: data one cycle after address.
    always @(posedge clk) begin
        bus.w_data <= wmem[bus.w_addr];
        bus.b_data <= bmem[bus.b_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push2(input int d0, input int d1);
        sbq.push_back(exp_t'{d0, 0, 0});
        sbq.push_back(exp_t'{d1, 1, 1});
    endtask

    // Stream xv[] with optional idle cycles between samples.
    task automatic send(input bit relu, input logic [SW-1:0] sh, input int gap);
        int guard;
        for (int i = 0; i < IN; i++) begin
            repeat (gap) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = xv[i];
            bus.relu_en  = relu;
            bus.shift    = sh;
            guard = 0;
            while (!bus.in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) chk("in_ready_timeout", 0, 1);
            if (i == IN - 1) last_accept = cyc;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((sbq.size() != 0 || bus.busy || bus.out_valid) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    // Monitor: out_valid rise timing plus data/idx/last on each handshake.
    initial begin
        bit   prev_v;
        int   last_hs;
        int   exp_edge;
        exp_t e;
        prev_v  = 1'b0;
        last_hs = -1000;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_v = 1'b0;
            end else begin
                if (bus.out_valid && !prev_v) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        exp_edge = (sbq[0].idx == 0) ? last_accept + IN + 2 : last_hs + IN + 2;
                        chk("out_valid_rise_edge", cyc - 1, exp_edge);
                    end
                end
                prev_v = bus.out_valid;
                if (bus.out_valid && bus.out_ready && sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("out_data", int'(bus.out_data), e.data);
                    chk("out_idx",  int'(bus.out_idx),  e.idx);
                    chk("out_last", int'(bus.out_last), e.last);
                    last_hs = cyc;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.relu_en   = 1'b0;
        bus.shift     = '0;
        bus.out_ready = 1'b1;
        wmem = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, -8'sd1, 8'sd0, 8'sd0, 8'sd0};
        bmem = '{32'sd10, 32'sd0};
        xv   = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};

        // Reset values
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  int'(bus.in_ready),  1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy",      int'(bus.busy),      0);
        chk("rst_w_addr",    int'(bus.w_addr),    0);
        chk("rst_b_addr",    int'(bus.b_addr),    0);
        chk("rst_out_data",  int'(bus.out_data),  0);
        chk("rst_out_idx",   int'(bus.out_idx),   0);
        chk("rst_out_last",  int'(bus.out_last),  0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic frame; config changes and in_valid pulses while busy must be ignored.
        push2(20, -1);
        send(1'b0, 5'd0, 0);
        bus.relu_en  = 1'b1;
        bus.shift    = 5'd10;
        bus.in_valid = 1'b1;
        bus.in_data  = -8'sd99;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        wait_idle();

        // ReLU, with idle gaps between samples.
        push2(20, 0);
        send(1'b1, 5'd0, 2);
        wait_idle();

        // Saturation in both directions.
        wmem = '{8'sd127, 8'sd127, 8'sd127, 8'sd127, -8'sd127, -8'sd127, -8'sd127, -8'sd127};
        bmem = '{32'sd0, 32'sd0};
        xv   = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
        push2(127, -128);
        send(1'b0, 5'd0, 0);
        wait_idle();

        // Shift by 10: 64516>>>10 = 63, -64516>>>10 = -64.
        push2(63, -64);
        send(1'b0, 5'd10, 1);
        wait_idle();

        // Backpressure on neuron 0: output and addresses frozen.
        wmem = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, -8'sd1, 8'sd0, 8'sd0, 8'sd0};
        bmem = '{32'sd10, 32'sd0};
        xv   = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        bus.out_ready = 1'b0;
        push2(20, -1);
        send(1'b0, 5'd0, 0);
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("stall_valid_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", int'(bus.out_valid), 1);
            chk("stall_out_data",  int'(bus.out_data),  20);
            chk("stall_w_addr",    int'(bus.w_addr),    3);
            chk("stall_b_addr",    int'(bus.b_addr),    0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_idle();

        // Reset during MAC discards the frame.
        send(1'b0, 5'd0, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_in_ready",  int'(bus.in_ready),  1);
        chk("midrst_busy",      int'(bus.busy),      0);
        chk("midrst_w_addr",    int'(bus.w_addr),    0);
        rstn = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready",  int'(bus.in_ready),  1);
        chk("postrst_out_valid", int'(bus.out_valid), 0);

        // Next frame after reset starts at buf[0].
        push2(20, -1);
        send(1'b0, 5'd0, 0);
        wait_idle();

        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
